// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the two-requester FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    localparam int unsigned NUM_REQ        = 2;
    localparam logic        LAST_GRANT_RST = 1'b1;

    // Saturation value of a drop counter of the given width (all ones).
    function automatic int unsigned drop_sat(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_req_slot.sv
// One-entry holding slot for a requester: captures ticks, counts ticks lost while occupied.
module fifo_req_slot
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned B      = 3,
    parameter int unsigned DROP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [B-1:0]      data,
    input  logic              served,
    output logic              pend,
    output logic [B-1:0]      hold,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(drop_sat(DROP_W));

    // A slot being written this cycle frees up in time to accept a new tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= 1'b0;
            hold     <= '0;
            drop_cnt <= '0;
        end else if (tick && (!pend || served)) begin
            pend <= 1'b1;
            hold <= data;
        end else if (tick) begin
            if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (served) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of a single FIFO write port between two tick-driven producers.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned B      = 3,
    parameter int unsigned DROP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_tick,
    input  logic [B-1:0]      req0_data,
    input  logic              req1_tick,
    input  logic [B-1:0]      req1_data,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [B-1:0]      fifo_w_data,
    output logic              grant_id,
    output logic              busy0,
    output logic              busy1,
    output logic [DROP_W-1:0] drop_cnt0,
    output logic [DROP_W-1:0] drop_cnt1
);

    logic [NUM_REQ-1:0] tick;
    logic [B-1:0]       data   [NUM_REQ];
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] served;
    logic [B-1:0]       hold   [NUM_REQ];
    logic [DROP_W-1:0]  drop   [NUM_REQ];
    logic               last_grant;
    logic               sel;

    assign tick    = {req1_tick, req0_tick};
    assign data[0] = req0_data;
    assign data[1] = req1_data;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        fifo_req_slot #(
            .B      (B),
            .DROP_W (DROP_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick[i]),
            .data     (data[i]),
            .served   (served[i]),
            .pend     (pend[i]),
            .hold     (hold[i]),
            .drop_cnt (drop[i])
        );
    end

    // Lone pending slot wins outright; a tie goes to the slot not granted last.
    always_comb begin
        sel = 1'b0;
        if (pend[0] && pend[1]) begin
            sel = ~last_grant;
        end else begin
            sel = pend[1];
        end
    end

    assign fifo_wr     = (|pend) & ~fifo_full;
    assign served[0]   = fifo_wr & ~sel;
    assign served[1]   = fifo_wr & sel;
    assign fifo_w_data = fifo_wr ? hold[sel] : '0;
    assign grant_id    = fifo_wr & sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= LAST_GRANT_RST;
        end else if (fifo_wr) begin
            last_grant <= sel;
        end
    end

    assign busy0     = pend[0];
    assign busy1     = pend[1];
    assign drop_cnt0 = drop[0];
    assign drop_cnt1 = drop[1];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a queue-based reference model.
module tb_fifo_wr_arbiter;

    localparam int unsigned B      = 3;
    localparam int unsigned DROP_W = 4;
    localparam int          SAT    = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_tick, req1_tick, fifo_full;
    logic [B-1:0]      req0_data, req1_data;
    logic              fifo_wr, grant_id, busy0, busy1;
    logic [B-1:0]      fifo_w_data;
    logic [DROP_W-1:0] drop_cnt0, drop_cnt1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.B(B), .DROP_W(DROP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_tick   (req0_tick),
        .req0_data   (req0_data),
        .req1_tick   (req1_tick),
        .req1_data   (req1_data),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy0       (busy0),
        .busy1       (busy1),
        .drop_cnt0   (drop_cnt0),
        .drop_cnt1   (drop_cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each requester owns a queue of at most one word.
    logic [B-1:0] q0[$];
    logic [B-1:0] q1[$];
    int           drops0, drops1;
    int           last_win;
    logic         ew;
    int           eid;
    logic [B-1:0] edata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        drops0   = 0;
        drops1   = 0;
        last_win = 1;
    endtask

    task automatic predict(input logic full);
        ew    = 1'b0;
        eid   = 0;
        edata = '0;
        if (!full && (q0.size() != 0 || q1.size() != 0)) begin
            ew = 1'b1;
            if (q0.size() != 0 && q1.size() != 0) eid = (last_win == 0) ? 1 : 0;
            else                                  eid = (q1.size() != 0) ? 1 : 0;
            edata = (eid == 1) ? q1[0] : q0[0];
        end
    endtask

    task automatic check_outputs(input logic full);
        predict(full);
        chk("fifo_wr",     32'(fifo_wr),     32'(ew));
        chk("fifo_w_data", 32'(fifo_w_data), 32'(edata));
        chk("grant_id",    32'(grant_id),    32'(eid));
        chk("busy0",       32'(busy0),       32'(q0.size() != 0));
        chk("busy1",       32'(busy1),       32'(q1.size() != 0));
        chk("drop_cnt0",   32'(drop_cnt0),   32'(drops0));
        chk("drop_cnt1",   32'(drop_cnt1),   32'(drops1));
    endtask

    // Apply inputs after the falling edge, check, then advance the model across the rising edge.
    task automatic cycle(input logic t0, input logic [B-1:0] d0,
                         input logic t1, input logic [B-1:0] d1, input logic full);
        req0_tick = t0;
        req0_data = d0;
        req1_tick = t1;
        req1_data = d1;
        fifo_full = full;
        #1;
        check_outputs(full);
        @(posedge clk);
        if (ew) begin
            if (eid == 0) void'(q0.pop_front());
            else          void'(q1.pop_front());
            last_win = eid;
        end
        if (t0) begin
            if (q0.size() == 0) q0.push_back(d0);
            else if (drops0 < SAT) drops0++;
        end
        if (t1) begin
            if (q1.size() == 0) q1.push_back(d1);
            else if (drops1 < SAT) drops1++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            req0_tick = i[0];
            req1_tick = ~i[0];
            req0_data = 3'(i + 1);
            req1_data = 3'(i + 4);
            fifo_full = 1'b0;
            #1;
            check_outputs(1'b0);
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req0_tick = 1'b0;
        req1_tick = 1'b0;
        req0_data = '0;
        req1_data = '0;
        fifo_full = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held with ticks toggling, then quiet
        apply_reset();
        idle(2);

        // Single tick from requester 0
        cycle(1'b1, 3'b101, 1'b0, '0, 1'b0);
        idle(2);

        // Three simultaneous pairs spaced two cycles apart
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 3'b001, 1'b1, 3'b110, 1'b0);
            idle(1);
        end
        idle(2);

        // Held while full, second tick dropped, drained on release
        cycle(1'b0, '0, 1'b1, 3'b011, 1'b1);
        cycle(1'b0, '0, 1'b1, 3'b100, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("drop_cnt1_after_full", 32'(drop_cnt1), 32'd1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        idle(2);

        // Drop counter saturation
        for (int i = 0; i < 20; i++) cycle(1'b1, 3'(i), 1'b0, '0, 1'b1);
        chk("drop_cnt0_saturated", 32'(drop_cnt0), 32'(SAT));
        idle(3);

        // Back-to-back ticks, then asynchronous reset mid-sequence
        apply_reset();
        cycle(1'b1, 3'b010, 1'b0, '0, 1'b0);
        cycle(1'b1, 3'b111, 1'b0, '0, 1'b0);
        req0_tick = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("busy0_async_reset",   32'(busy0),   32'd0);
        chk("fifo_wr_async_reset", 32'(fifo_wr), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Randomized traffic with intermittent back-pressure
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom),
                  ($urandom_range(0, 3) == 0));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
